rr_arbiter_8: RTL

- 8-requester round-robin arbiter for one shared resource.
- Grants the resource to one requester at a time and reports the grant both as a 3-bit index and as a one-hot vector.
- The one-hot vector is produced by decoding the registered grant index.
- A hold-time limit prevents any single requester from starving the others.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/dec_3to8.sv | 21 ++
 rtl/rr_pick_8.sv | 36 +++
 rtl/rr_arbiter_8.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants, state encoding and helpers for the 8-way round-robin
// arbiter (rr_arbiter_8) and its rotating-priority search (rr_pick_8).
//   N_REQ          number of requesters
//   ID_W           width of a requester index
//   arb_state_t    arbiter FSM state (ST_IDLE / ST_GRANT)
//   RESET_LAST_ID  "previous winner" after reset, so requester 0 leads
//   id_add()       requester index arithmetic with mod-N_REQ wrap
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam logic [ID_W-1:0] RESET_LAST_ID = 3'd7;

  // Wraps naturally because the result is truncated to ID_W bits and
  // N_REQ is exactly 2**ID_W.
  function automatic logic [ID_W-1:0] id_add(input logic [ID_W-1:0] base,
                                             input int               off);
    int sum;
    sum    = int'(base) + off;
    id_add = ID_W'(sum);
  endfunction

endpackage

// File: rtl/dec_3to8.sv
// -----------------------------------------------------------------------------
// dec_3to8
// Shared 3-to-8 one-hot decoder with enable.
//   i_sel  in  3  index to decode
//   i_en   in  1  when low the output is all zero
//   o_dec  out 8  one-hot decode of i_sel, or 8'h00 when disabled
// -----------------------------------------------------------------------------
module dec_3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_dec
);

  always_comb begin
    o_dec = 8'h00;
    if (i_en) begin
      o_dec[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_pick_8.sv
// -----------------------------------------------------------------------------
// rr_pick_8
// Combinational rotating-priority search. Starting just after last_id and
// wrapping mod 8, returns the first requester whose req bit is set.
//   req      in  8  request vector
//   last_id  in  3  previous winner; it gets the lowest priority
//   any      out 1  high when at least one request is present
//   win_id   out 3  selected requester (0 when any is low)
// -----------------------------------------------------------------------------
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  logic [ID_W-1:0] w_win;

  // Walk the offsets from farthest (N_REQ, i.e. last_id itself) to nearest
  // (1); the last hit overwrites earlier ones, so the nearest set bit after
  // last_id wins without needing an early exit.
  always_comb begin
    w_win = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[id_add(last_id, k)]) begin
        w_win = id_add(last_id, k);
      end
    end
  end

  assign any    = |req;
  assign win_id = w_win;

endmodule

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
// 8-requester round-robin arbiter for one shared resource with a hold-time
// limit. A grant is issued one clock after the request is sampled, is kept
// while the owner holds its req bit, and is revoked after MAX_HOLD cycles of
// continuous ownership (MAX_HOLD = 0 disables the limit). Every release is
// followed by one idle cycle with no grant; the next search starts just after
// the released requester.
//   clk        in  1  clock, rising edge
//   rst_n      in  1  asynchronous active-low reset
//   req        in  8  request vector, bit i = requester i
//   gnt        out 8  one-hot grant, 8'h00 when no grant is active
//   gnt_id     out 3  current or most recent winner
//   gnt_valid  out 1  high while a grant is active
//   timeout    out 1  one-cycle pulse after a grant is revoked by the limit
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles, 0 = unlimited (0..255)
//   HOLD_W     hold counter width, 2**HOLD_W > MAX_HOLD
// -----------------------------------------------------------------------------
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit              HOLD_LIMITED = (MAX_HOLD != 0);
  // Counter value seen on the last permitted ownership cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST  =
    HOLD_LIMITED ? HOLD_W'(MAX_HOLD - 1) : '0;

  // Hold counter increment that sticks at all-ones instead of wrapping;
  // only reachable when the limit is disabled.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] cnt);
    if (&cnt) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + 1'b1;
    end
  endfunction

  function automatic logic hold_expired(input logic [HOLD_W-1:0] cnt);
    hold_expired = HOLD_LIMITED && (cnt == HOLD_LAST);
  endfunction

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_gnt_id;
  logic [ID_W-1:0]   r_last_id;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  arb_state_t        w_state_nxt;
  logic [ID_W-1:0]   w_gnt_id_nxt;
  logic [ID_W-1:0]   w_last_id_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_timeout_nxt;

  logic              w_pick_any;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_gnt_valid;

  rr_pick_8 u_pick (
    .req     (req),
    .last_id (r_last_id),
    .any     (w_pick_any),
    .win_id  (w_pick_id)
  );

  // ---- next-state decision ----
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_id_nxt = r_last_id;
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_id_nxt = w_pick_id;
          w_hold_nxt   = '0;
        end
      end

      ST_GRANT: begin
        // A voluntary release takes precedence; the limit only applies
        // while the owner is still asking for the resource.
        if (!req[r_gnt_id]) begin
          w_state_nxt   = ST_IDLE;
          w_last_id_nxt = r_gnt_id;
        end else if (hold_expired(r_hold_cnt)) begin
          w_state_nxt   = ST_IDLE;
          w_last_id_nxt = r_gnt_id;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = sat_inc(r_hold_cnt);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt_id   <= '0;
      r_last_id  <= RESET_LAST_ID;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_last_id  <= w_last_id_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // ---- outputs ----
  assign w_gnt_valid = (r_state == ST_GRANT);

  dec_3to8 u_dec (
    .i_sel (r_gnt_id),
    .i_en  (w_gnt_valid),
    .o_dec (gnt)
  );

  assign gnt_id    = r_gnt_id;
  assign gnt_valid = w_gnt_valid;
  assign timeout   = r_timeout;

endmodule
